// File: rtl/main_control_fsm.sv
// Main control FSM for a multi-cycle 16-bit datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives the datapath strobes,
// times out stalled data-memory accesses and counts retired instructions.
//
// Handshakes: an instruction is accepted in FETCH on a cycle where
// imem_valid=1 (ir_write/pc_write pulse that same cycle); a data access
// completes in MEM on a cycle where dmem_ready=1, and mem_read/mem_write
// stay asserted and stable until then.
module main_control_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        imem_valid,
  input  logic        dmem_ready,
  output logic [3:0]  ALUop,
  output logic [3:0]  FuncCode,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        branch,
  output logic        jump,
  output logic [2:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_J    = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_FUNC = 4'b1111;

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [15:0]   ir_q;
  logic [CW-1:0] wait_cnt;
  logic [15:0]   count_q;
  logic          post_rst;
  logic          accept;
  logic          retire;
  logic [3:0]    opcode;

  // Strobe values before the reset gate
  logic [3:0] alu_op_c;
  logic       ir_write_c, pc_write_c, reg_write_c, mem_read_c;
  logic       mem_write_c, alu_src_c, branch_c, jump_c;

  // rd/rs fields are carried in IR for the datapath but not decoded here
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir_q[11:4];

  assign opcode = ir_q[15:12];

  // The cycle right after reset never accepts, so strobes stay quiet then
  assign accept = (state_q == S_FETCH) && imem_valid && !post_rst;

  // State, IR, MEM wait counter and retire counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      ir_q     <= 16'h0000;
      wait_cnt <= '0;
      count_q  <= 16'h0000;
      post_rst <= 1'b1;
    end else begin
      state_q  <= state_d;
      post_rst <= 1'b0;
      if (accept) begin
        ir_q <= instr;
      end
      if (state_q != S_MEM) begin
        wait_cnt <= '0;
      end else if (!dmem_ready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (retire && (count_q != 16'hFFFF)) begin
        count_q <= count_q + 16'h0001;
      end
    end
  end

  // Next-state decode and Moore strobes (FETCH also looks at imem_valid)
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    alu_op_c    = ALU_ADD;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    alu_src_c   = 1'b0;
    branch_c    = 1'b0;
    jump_c      = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_c = accept;
        pc_write_c = accept;
        if (accept) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_J: begin
            jump_c     = 1'b1;
            pc_write_c = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
          end
          OP_HALT: begin
            retire  = 1'b1;
            state_d = S_HALT;
          end
          OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
          default: state_d = S_ERROR;
        endcase
      end
      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_op_c = ALU_FUNC;
            state_d  = S_WB;
          end
          OP_ADDI: begin
            alu_src_c = 1'b1;
            state_d   = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_c = 1'b1;
            state_d   = S_MEM;
          end
          OP_BEQ: begin
            alu_op_c = ALU_SUB;
            branch_c = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_ERROR;
        endcase
      end
      S_MEM: begin
        alu_src_c   = 1'b1;
        mem_read_c  = (opcode == OP_LW);
        mem_write_c = (opcode == OP_SW);
        if ((opcode != OP_LW) && (opcode != OP_SW)) begin
          state_d = S_ERROR;
        end else if (dmem_ready) begin
          // Completion wins over a timeout landing on the same cycle
          if (opcode == OP_LW) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          state_d = S_ERROR;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  // While reset is held every strobe and the ALU controls read as zero
  always_comb begin
    ALUop     = rst_n ? alu_op_c : 4'b0000;
    FuncCode  = rst_n ? ir_q[3:0] : 4'b0000;
    ir_write  = rst_n & ir_write_c;
    pc_write  = rst_n & pc_write_c;
    reg_write = rst_n & reg_write_c;
    mem_read  = rst_n & mem_read_c;
    mem_write = rst_n & mem_write_c;
    alu_src   = rst_n & alu_src_c;
    branch    = rst_n & branch_c;
    jump      = rst_n & jump_c;
  end

  assign state       = state_q;
  assign halted      = (state_q == S_HALT);
  assign illegal     = (state_q == S_ERROR);
  assign instr_count = count_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: one task per scenario, each
// comparing DUT outputs against hand-computed values.
module tb_main_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        imem_valid = 1'b0;
  logic        dmem_ready = 1'b0;
  logic [3:0]  ALUop, FuncCode;
  logic        ir_write, pc_write, reg_write, mem_read, mem_write;
  logic        alu_src, branch, jump, halted, illegal;
  logic [2:0]  state;
  logic [15:0] instr_count;

  int n_checks = 0;
  int n_fail = 0;

  // {ir_write,pc_write,reg_write,mem_read,mem_write,alu_src,branch,jump}
  logic [7:0] strb;
  assign strb = {ir_write, pc_write, reg_write, mem_read, mem_write, alu_src, branch, jump};

  main_control_fsm #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_valid(imem_valid),
    .dmem_ready(dmem_ready), .ALUop(ALUop), .FuncCode(FuncCode),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
    .branch(branch), .jump(jump), .state(state), .halted(halted),
    .illegal(illegal), .instr_count(instr_count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word in FETCH, check the accept strobes, leave the FSM in DECODE
  task automatic fetch(input logic [15:0] w);
    instr = w;
    imem_valid = 1'b1;
    #1;
    n_checks++;
    if (state !== 3'd0 || strb !== 8'hC0) begin
      n_fail++;
      $display("FAIL fetch_accept %h: state=%0d strb=%b, want state=0 strb=11000000", w, state, strb);
    end
    tick();
    imem_valid = 1'b0;
    instr = 16'hFFFF;
    #1;
    n_checks++;
    if (state !== 3'd1) begin
      n_fail++;
      $display("FAIL decode_entry %h: state=%0d want 1", w, state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_valid = 1'b1;
    dmem_ready = 1'b0;
    instr = 16'hFFFF;
    #1;
    n_checks++;
    if (strb !== 8'h00 || ALUop !== 4'h0 || FuncCode !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_during: strb=%b ALUop=%h FuncCode=%h, want all 0", strb, ALUop, FuncCode);
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (state !== 3'd0 || strb !== 8'h00 || ALUop !== 4'h0 || FuncCode !== 4'h0 ||
        instr_count !== 16'd0 || halted !== 1'b0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after: state=%0d strb=%b ALUop=%h Func=%h cnt=%0d h=%b i=%b, want 0s",
               state, strb, ALUop, FuncCode, instr_count, halted, illegal);
    end
    tick();
    imem_valid = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_no_accept: state=%0d want 0", state);
    end
  endtask

  task automatic test_rtype();
    fetch(16'h0125);
    n_checks++;
    if (strb !== 8'h00 || ALUop !== 4'h0 || FuncCode !== 4'h5) begin
      n_fail++;
      $display("FAIL rtype_decode: strb=%b ALUop=%h Func=%h want 0/0/5", strb, ALUop, FuncCode);
    end
    tick();
    n_checks++;
    if (state !== 3'd2 || ALUop !== 4'hF || FuncCode !== 4'h5 || strb !== 8'h00) begin
      n_fail++;
      $display("FAIL rtype_exec: state=%0d ALUop=%h Func=%h strb=%b want 2/F/5/0", state, ALUop, FuncCode, strb);
    end
    tick();
    n_checks++;
    if (state !== 3'd4 || strb !== 8'h20 || ALUop !== 4'h0) begin
      n_fail++;
      $display("FAIL rtype_wb: state=%0d strb=%b ALUop=%h want 4/00100000/0", state, strb, ALUop);
    end
    tick();
    n_checks++;
    if (state !== 3'd0 || instr_count !== 16'd1 || strb !== 8'h00) begin
      n_fail++;
      $display("FAIL rtype_retire: state=%0d cnt=%0d strb=%b want 0/1/0", state, instr_count, strb);
    end
  endtask

  task automatic test_lw_wait();
    int reads = 0;
    fetch(16'h2130);
    tick();
    n_checks++;
    if (state !== 3'd2 || strb !== 8'h04 || ALUop !== 4'h0) begin
      n_fail++;
      $display("FAIL lw_exec: state=%0d strb=%b ALUop=%h want 2/00000100/0", state, strb, ALUop);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      #1;
      if (state === 3'd3 && strb === 8'h14 && ALUop === 4'h0) reads++;
      tick();
    end
    dmem_ready = 1'b0;
    #1;
    n_checks++;
    if (reads !== 4) begin
      n_fail++;
      $display("FAIL lw_mem_read_cycles: got %0d want 4", reads);
    end
    n_checks++;
    if (state !== 3'd4 || strb !== 8'h20) begin
      n_fail++;
      $display("FAIL lw_wb: state=%0d strb=%b want 4/00100000", state, strb);
    end
    tick();
    n_checks++;
    if (state !== 3'd0 || instr_count !== 16'd2) begin
      n_fail++;
      $display("FAIL lw_retire: state=%0d cnt=%0d want 0/2", state, instr_count);
    end
  endtask

  task automatic test_beq_j();
    fetch(16'h4000);
    tick();
    n_checks++;
    if (state !== 3'd2 || ALUop !== 4'h1 || strb !== 8'h02) begin
      n_fail++;
      $display("FAIL beq_exec: state=%0d ALUop=%h strb=%b want 2/1/00000010", state, ALUop, strb);
    end
    tick();
    n_checks++;
    if (state !== 3'd0 || instr_count !== 16'd3 || strb !== 8'h00) begin
      n_fail++;
      $display("FAIL beq_retire: state=%0d cnt=%0d strb=%b want 0/3/0", state, instr_count, strb);
    end
    fetch(16'h5000);
    n_checks++;
    if (strb !== 8'h41 || ALUop !== 4'h0) begin
      n_fail++;
      $display("FAIL j_decode: strb=%b ALUop=%h want 01000001/0", strb, ALUop);
    end
    tick();
    n_checks++;
    if (state !== 3'd0 || instr_count !== 16'd4) begin
      n_fail++;
      $display("FAIL j_retire: state=%0d cnt=%0d want 0/4", state, instr_count);
    end
  endtask

  task automatic test_back_to_back();
    fetch(16'h1234);
    tick();
    n_checks++;
    if (state !== 3'd2 || strb !== 8'h04 || ALUop !== 4'h0 || FuncCode !== 4'h4) begin
      n_fail++;
      $display("FAIL addi_exec: state=%0d strb=%b ALUop=%h Func=%h want 2/00000100/0/4", state, strb, ALUop, FuncCode);
    end
    tick();
    n_checks++;
    if (state !== 3'd4 || strb !== 8'h20) begin
      n_fail++;
      $display("FAIL addi_wb: state=%0d strb=%b want 4/00100000", state, strb);
    end
    tick();
    // SW whose dmem_ready arrives on the 15th MEM cycle: completion wins
    fetch(16'h3007);
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      dmem_ready = (i == 14);
      tick();
    end
    dmem_ready = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0 || instr_count !== 16'd6 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_ready_at_limit: state=%0d cnt=%0d illegal=%b want 0/6/0", state, instr_count, illegal);
    end
  endtask

  task automatic test_sw_timeout();
    int writes = 0;
    fetch(16'h3000);
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      if (state === 3'd3 && strb === 8'h0C) writes++;
      tick();
    end
    n_checks++;
    if (writes !== 15) begin
      n_fail++;
      $display("FAIL sw_mem_write_cycles: got %0d want 15", writes);
    end
    n_checks++;
    if (state !== 3'd6 || illegal !== 1'b1 || strb !== 8'h00 || instr_count !== 16'd6) begin
      n_fail++;
      $display("FAIL sw_timeout: state=%0d illegal=%b strb=%b cnt=%0d want 6/1/0/6", state, illegal, strb, instr_count);
    end
  endtask

  task automatic test_illegal();
    fetch(16'h7000);
    tick();
    imem_valid = 1'b1;
    tick();
    tick();
    imem_valid = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd6 || illegal !== 1'b1 || strb !== 8'h00 || instr_count !== 16'd0) begin
      n_fail++;
      $display("FAIL illegal_op: state=%0d illegal=%b strb=%b cnt=%0d want 6/1/0/0", state, illegal, strb, instr_count);
    end
  endtask

  task automatic test_halt();
    int stuck = 0;
    fetch(16'hF000);
    tick();
    n_checks++;
    if (state !== 3'd5 || halted !== 1'b1 || instr_count !== 16'd1) begin
      n_fail++;
      $display("FAIL halt_entry: state=%0d halted=%b cnt=%0d want 5/1/1", state, halted, instr_count);
    end
    for (int i = 0; i < 6; i++) begin
      imem_valid = i[0];
      instr = 16'h0125;
      #1;
      if (state === 3'd5 && halted === 1'b1 && strb === 8'h00) stuck++;
      tick();
    end
    n_checks++;
    if (stuck !== 6) begin
      n_fail++;
      $display("FAIL halt_sticky: got %0d good cycles want 6", stuck);
    end
    test_reset();
    n_checks++;
    if (halted !== 1'b0 || instr_count !== 16'd0) begin
      n_fail++;
      $display("FAIL halt_reset: halted=%b cnt=%0d want 0/0", halted, instr_count);
    end
  endtask

  task automatic test_reset_mid_mem();
    fetch(16'h2130);
    tick();
    tick();
    tick();
    n_checks++;
    if (state !== 3'd3 || mem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL midmem_setup: state=%0d mem_read=%b want 3/1", state, mem_read);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (state !== 3'd0 || mem_read !== 1'b0 || instr_count !== 16'd0 || FuncCode !== 4'h0) begin
      n_fail++;
      $display("FAIL midmem_reset: state=%0d mem_read=%b cnt=%0d Func=%h want 0/0/0/0", state, mem_read, instr_count, FuncCode);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq_j();
    test_back_to_back();
    test_sw_timeout();
    test_reset();
    test_illegal();
    test_reset();
    test_halt();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
